// File: rtl/traffic_pkg.sv
// traffic_pkg: shared constants for the two-approach intersection controller.
// Lamp triplets are {Red,Yellow,Green}. The phase enum is the encoding that the
// controller reports on its phase output.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] OFF    = 3'b000;

    typedef enum logic [2:0] {
        StNsGreen  = 3'd0,
        StNsYellow = 3'd1,
        StClrA     = 3'd2,
        StEwGreen  = 3'd3,
        StEwYellow = 3'd4,
        StClrB     = 3'd5,
        StFlashOn  = 3'd6,
        StFlashOff = 3'd7
    } state_e;

endpackage

// File: rtl/traffic_if.sv
// traffic_if: controller-facing signal bundle.
//   tick     - time-base strobe from the prescaler
//   ped_req  - pedestrian button (level or pulse)
//   flash_en - maintenance flash request (level)
//   ns_light, ew_light - lamp triplets {Red,Yellow,Green}
//   ped_walk - walk indication
//   phase    - current controller state encoding
// master: the environment (prescaler, buttons, lamp drivers); slave: the controller.
interface traffic_if;
    logic       tick;
    logic       ped_req;
    logic       flash_en;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ped_walk;
    logic [2:0] phase;

    modport master (
        output tick, ped_req, flash_en,
        input  ns_light, ew_light, ped_walk, phase
    );

    modport slave (
        input  tick, ped_req, flash_en,
        output ns_light, ew_light, ped_walk, phase
    );
endinterface

// File: rtl/traffic_controller_dwell_timer.sv
// dwell_timer: per-phase down counter advanced by tick strobes.
//   clk, reset - clock and synchronous active-high reset (loads RESET_VAL)
//   tick       - counting strobe
//   load       - load load_val this cycle (takes priority over counting)
//   load_val   - duration minus one of the phase being entered
//   expire     - tick arrived while the count is zero; the phase ends on this edge
module dwell_timer #(
    parameter int unsigned      CNT_W     = 8,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VAL;
        end else if (load) begin
            count_q <= load_val;
        end else if (tick && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expire = tick && (count_q == '0);

endmodule

// File: rtl/traffic_controller.sv
// traffic_controller: two-approach intersection controller.
//   clk   - system clock
//   reset - synchronous active-high reset (state CLR_B, all-red, latch clear)
//   bus   - traffic_if.slave: tick/ped_req/flash_en in; lamps, ped_walk, phase out
// Sequence CLR_B -> NS_GREEN -> NS_YELLOW -> CLR_A -> EW_GREEN -> EW_YELLOW -> CLR_B,
// with a latched pedestrian request turning CLR_B into a walk phase and a yellow
// flash mode entered and left only through the all-red clearance phases.
module traffic_controller
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned GREEN_TICKS  = 10,
    parameter int unsigned YELLOW_TICKS = 3,
    parameter int unsigned ALLRED_TICKS = 2,
    parameter int unsigned WALK_TICKS   = 6,
    parameter int unsigned FLASH_TICKS  = 4
) (
    input  logic clk,
    input  logic reset,
    traffic_if.slave bus
);

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_TICKS - 1);

    state_e           state_q, state_d;
    logic             ped_q, ped_d;
    // Set while the current CLR_B is serving a pedestrian walk.
    logic             walk_q, walk_d;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             expire;

    dwell_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (ALLRED_LD)
    ) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (bus.tick),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StClrB;
            ped_q   <= 1'b0;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ped_q   <= ped_d;
            walk_q  <= walk_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ped_d    = ped_q | bus.ped_req;
        walk_d   = walk_q;
        load     = 1'b0;
        load_val = ALLRED_LD;
        if (expire) begin
            load   = 1'b1;
            walk_d = 1'b0;
            case (state_q)
                StNsGreen: begin
                    state_d  = StNsYellow;
                    load_val = YELLOW_LD;
                end
                StNsYellow: begin
                    state_d  = StClrA;
                    load_val = ALLRED_LD;
                end
                StClrA: begin
                    state_d  = bus.flash_en ? StFlashOn : StEwGreen;
                    load_val = bus.flash_en ? FLASH_LD : GREEN_LD;
                end
                StEwGreen: begin
                    state_d  = StEwYellow;
                    load_val = YELLOW_LD;
                end
                StEwYellow: begin
                    state_d = StClrB;
                    if (ped_q) begin
                        // Serve the request; a button still held re-arms the latch.
                        load_val = WALK_LD;
                        walk_d   = 1'b1;
                        ped_d    = bus.ped_req;
                    end else begin
                        load_val = ALLRED_LD;
                    end
                end
                StClrB: begin
                    state_d  = bus.flash_en ? StFlashOn : StNsGreen;
                    load_val = bus.flash_en ? FLASH_LD : GREEN_LD;
                end
                StFlashOn: begin
                    state_d  = StFlashOff;
                    load_val = FLASH_LD;
                end
                StFlashOff: begin
                    state_d  = bus.flash_en ? StFlashOn : StClrB;
                    load_val = bus.flash_en ? FLASH_LD : ALLRED_LD;
                end
                default: begin
                    state_d  = StClrB;
                    load_val = ALLRED_LD;
                end
            endcase
        end
    end

    always_comb begin
        bus.ns_light = RED;
        bus.ew_light = RED;
        case (state_q)
            StNsGreen:  bus.ns_light = GREEN;
            StNsYellow: bus.ns_light = YELLOW;
            StEwGreen:  bus.ew_light = GREEN;
            StEwYellow: bus.ew_light = YELLOW;
            StFlashOn: begin
                bus.ns_light = YELLOW;
                bus.ew_light = YELLOW;
            end
            StFlashOff: begin
                bus.ns_light = OFF;
                bus.ew_light = OFF;
            end
            default: begin
                bus.ns_light = RED;
                bus.ew_light = RED;
            end
        endcase
    end

    assign bus.ped_walk = walk_q && (state_q == StClrB);
    assign bus.phase    = state_q;

endmodule
